counter_sweep_ctrl: RTL and testbench

//  Sequencer for the up/down counter datapath. On a start request it loads a

---
 rtl/counter_sweep_ctrl.sv | 143 ++++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer for the up/down counter datapath.
// Loads a start value, steps toward an end value, optionally bounces back.
module counter_sweep_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic [WIDTH-1:0] cfg_end,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_bounce,
  input  logic             abort,
  input  logic [WIDTH-1:0] ctr_count,
  output logic             ctr_set,
  output logic [WIDTH-1:0] ctr_set_value,
  output logic             ctr_ena,
  output logic             ctr_up_down,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] end_q, end_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             bounce_q, bounce_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             leg_q, leg_d;
  logic [DIV_W-1:0] pcnt_q, pcnt_d;
  logic             aborted_q, aborted_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      start_q   <= '0;
      end_q     <= '0;
      div_q     <= '0;
      bounce_q  <= 1'b0;
      dir_q     <= 1'b0;
      target_q  <= '0;
      leg_q     <= 1'b0;
      pcnt_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      end_q     <= end_d;
      div_q     <= div_d;
      bounce_q  <= bounce_d;
      dir_q     <= dir_d;
      target_q  <= target_d;
      leg_q     <= leg_d;
      pcnt_q    <= pcnt_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    start_d       = start_q;
    end_d         = end_q;
    div_d         = div_q;
    bounce_d      = bounce_q;
    dir_d         = dir_q;
    target_d      = target_q;
    leg_d         = leg_q;
    pcnt_d        = pcnt_q;
    aborted_d     = aborted_q;
    ctr_set       = 1'b0;
    ctr_set_value = '0;
    ctr_ena       = 1'b0;
    ctr_up_down   = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          start_d   = cfg_start;
          end_d     = cfg_end;
          div_d     = cfg_div;
          bounce_d  = cfg_bounce;
          aborted_d = 1'b0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        ctr_set       = 1'b1;
        ctr_set_value = start_q;
        dir_d         = (end_q >= start_q);
        target_d      = end_q;
        leg_d         = 1'b0;
        pcnt_d        = '0;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        ctr_up_down = dir_q;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (ctr_count == target_q) begin
          // Turn around once, unless the sweep is degenerate
          if (bounce_q && !leg_q && (start_q != end_q)) begin
            target_d = start_q;
            dir_d    = ~dir_q;
            leg_d    = 1'b1;
            pcnt_d   = '0;
          end else begin
            state_d = S_DONE;
          end
        end else if (pcnt_q == div_q) begin
          ctr_ena = 1'b1;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign aborted = aborted_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Scoreboard bench for counter_sweep_ctrl with a behavioural counter.
// Expected strobe events are queued per sweep and matched as they occur.
module tb_counter_sweep_ctrl;

  localparam int WIDTH = 4;
  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] cfg_start;
  logic [WIDTH-1:0] cfg_end;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_bounce;
  logic             abort;
  logic [WIDTH-1:0] ctr_count;
  logic             ctr_set;
  logic [WIDTH-1:0] ctr_set_value;
  logic             ctr_ena;
  logic             ctr_up_down;
  logic             busy;
  logic             done;
  logic             aborted;

  counter_sweep_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cfg_start     (cfg_start),
    .cfg_end       (cfg_end),
    .cfg_div       (cfg_div),
    .cfg_bounce    (cfg_bounce),
    .abort         (abort),
    .ctr_count     (ctr_count),
    .ctr_set       (ctr_set),
    .ctr_set_value (ctr_set_value),
    .ctr_ena       (ctr_ena),
    .ctr_up_down   (ctr_up_down),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted)
  );

  always #5 clk = ~clk;

  initial ctr_count = '0;
  always @(posedge clk) begin
    if (ctr_set) ctr_count <= ctr_set_value;
    else if (ctr_ena)
      ctr_count <= ctr_up_down ? ctr_count + 4'd1 : ctr_count - 4'd1;
  end

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] cyc;
    logic [3:0]  val;
  } ev_t;

  localparam logic [1:0] K_SET  = 2'd0;
  localparam logic [1:0] K_ENA  = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;

  ev_t exp_q[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic add_ev(input logic [1:0] k, input int c, input int v,
                        input int a);
    ev_t e;
    if (a == 0 || c < a) begin
      e.kind = k;
      e.cyc  = 16'(c);
      e.val  = 4'(v);
      exp_q.push_back(e);
    end
  endtask

  task automatic gen(input int s, input int e, input int d, input int b,
                     input int a);
    int n, m, up, ab;
    n  = (e >= s) ? e - s : s - e;
    up = (e >= s) ? 1 : 0;
    m  = 2;
    add_ev(K_SET, 1, s, a);
    if (n > 0) begin
      for (int k = 0; k < n; k++) add_ev(K_ENA, 2 + d + k * (d + 1), up, a);
      m = 2 + n * (d + 1);
      if (b != 0) begin
        for (int k = 0; k < n; k++)
          add_ev(K_ENA, m + 1 + d + k * (d + 1), 1 - up, a);
        m = m + 1 + n * (d + 1);
      end
    end
    ab = (a != 0 && a <= m) ? 1 : 0;
    add_ev(K_DONE, (ab != 0) ? a + 1 : m + 1, ab, 0);
  endtask

  task automatic observe(input int c, input string tag);
    ev_t o, x;
    if (ctr_set || ctr_ena || done) begin
      o.kind = ctr_set ? K_SET : (ctr_ena ? K_ENA : K_DONE);
      o.cyc  = 16'(c);
      o.val  = ctr_set ? ctr_set_value : (ctr_ena ? {3'b0, ctr_up_down}
                                                  : {3'b0, aborted});
      x = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check(tag, 32'(o), 32'(x));
    end
  endtask

  task automatic run(input string tag, input int s, input int e, input int d,
                     input int b, input int a, input int sp,
                     input int exp_cnt);
    int c;
    logic seen;
    logic exp_ab;
    gen(s, e, d, b, a);
    exp_ab = (exp_q.size() > 0) ? exp_q[$].val[0] : 1'b0;
    @(negedge clk);
    cfg_start  = 4'(s);
    cfg_end    = 4'(e);
    cfg_div    = 8'(d);
    cfg_bounce = b[0];
    start      = 1'b1;
    c          = 0;
    seen       = 1'b0;
    while (!seen && c < 400) begin
      @(negedge clk);
      c++;
      start = (c == sp);
      if (c == sp) begin
        cfg_start = 4'd15;
        cfg_end   = 4'd0;
        cfg_div   = 8'd0;
      end
      abort = (a != 0 && c == a);
      #1;
      observe(c, tag);
      seen = done;
    end
    if (!seen) check({tag, "_timeout"}, 32'(c), 32'(0));
    check({tag, "_left"}, 32'(exp_q.size()), 32'(0));
    exp_q.delete();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    #1;
    check({tag, "_count"}, 32'(ctr_count), 32'(exp_cnt));
    check({tag, "_idle"}, {30'b0, aborted, busy}, {30'b0, exp_ab, 1'b0});
  endtask

  function automatic logic [31:0] outs();
    return {21'b0, ctr_set, ctr_set_value, ctr_ena, ctr_up_down,
            busy, done, aborted};
  endfunction

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    cfg_start  = '0;
    cfg_end    = '0;
    cfg_div    = '0;
    cfg_bounce = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", outs(), 32'(0));
    reset = 1'b0;

    run("t1_up",      2,  5, 0, 0, 0, 0, 5);
    run("t2_down",    9,  6, 2, 0, 0, 0, 6);
    run("t3_bounce",  0, 15, 0, 1, 0, 0, 0);
    run("t4_equal",   7,  7, 0, 0, 0, 0, 7);
    run("t5_abort",   2,  5, 0, 0, 3, 0, 3);
    run("t6_busystart", 3, 1, 1, 1, 0, 4, 3);
    run("t7_eqbounce", 7, 7, 0, 1, 0, 0, 7);
    run("t8_abortend", 4, 6, 0, 0, 4, 0, 6);

    @(negedge clk);
    cfg_start  = 4'd2;
    cfg_end    = 4'd5;
    cfg_div    = 8'd0;
    cfg_bounce = 1'b0;
    start      = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    check("pre_reset_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_reset_outs", outs(), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("post_reset_quiet", outs(), 32'(0));
    end

    run("t9_after_reset", 1, 3, 1, 0, 0, 0, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
